ladder_arbiter: RTL and testbench

// Shares one mont_ladder scalar-multiplication core ([s]P, projective X/Y/Z, Montgomery domain)

---
 rtl/ladder_arbiter.sv | 124 ++++++++++++
 tb/tb_ladder_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladder_arbiter.sv
// ladder_arbiter: round-robin sharing of one mont_ladder core with tagged responses; define LADDER_TIMEOUT_EN to add a WAIT watchdog
module ladder_arbiter #(
  parameter int DATA_WIDTH     = 448,
  parameter int SCALAR_WIDTH   = 456,
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 2**20,
  localparam int ID_W          = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*SCALAR_WIDTH-1:0] req_s,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_X,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_Y,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_Z,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_X,
  output logic [DATA_WIDTH-1:0]         rsp_Y,
  output logic [DATA_WIDTH-1:0]         rsp_Z,
  output logic                          rsp_err,
  output logic                          lad_start,
  output logic [SCALAR_WIDTH-1:0]       lad_s,
  output logic [DATA_WIDTH-1:0]         lad_X,
  output logic [DATA_WIDTH-1:0]         lad_Y,
  output logic [DATA_WIDTH-1:0]         lad_Z,
  input  logic [DATA_WIDTH-1:0]         lad_X_out,
  input  logic [DATA_WIDTH-1:0]         lad_Y_out,
  input  logic [DATA_WIDTH-1:0]         lad_Z_out,
  input  logic                          lad_done
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  logic [1:0]              state_q, state_d;
  logic [ID_W-1:0]         rr_q, id_q, grant, idx;
  logic                    any_v, accept, qual, to_hit, seen_low_q, err_q;
  logic [SCALAR_WIDTH-1:0] s_q;
  logic [DATA_WIDTH-1:0]   x_q, y_q, z_q, rx_q, ry_q, rz_q;
  // First valid requester after the last grant, wrapping around
  always_comb begin
    grant = rr_q;
    idx = '0;
    any_v = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(rr_q) + k) % N_REQ);
      if (!any_v && req_valid[idx]) begin
        any_v = 1'b1;
        grant = idx;
      end
    end
  end
  assign req_ready = (state_q == S_IDLE && any_v) ? (N_REQ'(1) << grant) : '0;
  assign accept    = |(req_valid & req_ready);
  assign qual      = state_q == S_WAIT && lad_done && seen_low_q;
`ifdef LADDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign to_hit = state_q == S_WAIT && !qual && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // Count WAIT cycles of the current job; restarts with every start pulse
  always_ff @(posedge clk) begin
    if (rst || state_q == S_START) cnt_q <= '0;
    else if (state_q == S_WAIT) cnt_q <= cnt_q + CW'(1);
  end
`else
  assign to_hit = 1'b0;
`endif
  // Job sequencing: accept, start pulse, wait for a fresh done, hold response
  always_comb begin
    state_d = state_q == S_IDLE  ? (accept ? S_START : S_IDLE) :
              state_q == S_START ? S_WAIT :
              state_q == S_WAIT  ? ((qual || to_hit) ? S_RESP : S_WAIT) :
                                   (rsp_ready ? S_IDLE : S_RESP);
  end
  // State, operand capture and result capture; done must be seen low inside WAIT before it counts
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= ID_W'(N_REQ - 1);
      id_q       <= '0;
      seen_low_q <= 1'b0;
      err_q      <= 1'b0;
      s_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      rz_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        s_q  <= req_s[int'(grant)*SCALAR_WIDTH +: SCALAR_WIDTH];
        x_q  <= req_X[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        y_q  <= req_Y[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        z_q  <= req_Z[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        id_q <= grant;
        rr_q <= grant;
      end
      if (state_q == S_START) seen_low_q <= 1'b0;
      else if (state_q == S_WAIT && !lad_done) seen_low_q <= 1'b1;
      if (qual || to_hit) begin
        rx_q  <= to_hit ? '0 : lad_X_out;
        ry_q  <= to_hit ? '0 : lad_Y_out;
        rz_q  <= to_hit ? '0 : lad_Z_out;
        err_q <= to_hit;
      end
    end
  end
  assign rsp_valid = state_q == S_RESP;
  assign rsp_id    = id_q;
  assign rsp_X     = rx_q;
  assign rsp_Y     = ry_q;
  assign rsp_Z     = rz_q;
  assign rsp_err   = err_q;
  assign lad_start = state_q == S_START;
  assign lad_s     = s_q;
  assign lad_X     = x_q;
  assign lad_Y     = y_q;
  assign lad_Z     = z_q;
endmodule

// File: tb/tb_ladder_arbiter.sv
// tb_ladder_arbiter: directed bench for ladder_arbiter with a behavioural ladder stub
module tb_ladder_arbiter;
  localparam int DW = 448;
  localparam int SW = 456;
  localparam int NR = 2;
`ifdef LADDER_TIMEOUT_EN
  localparam int TO = 16;
  localparam int HI = 4;
  localparam int LO = 8;
`else
  localparam int TO = 2**20;
  localparam int HI = 10;
  localparam int LO = 40;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*SW-1:0] req_s = '0;
  logic [NR*DW-1:0] req_X = '0, req_Y = '0, req_Z = '0;
  logic rsp_valid, rsp_err, lad_start, lad_done;
  logic rsp_ready = 1'b0;
  logic [0:0] rsp_id;
  logic [DW-1:0] rsp_X, rsp_Y, rsp_Z, lad_X, lad_Y, lad_Z, lad_X_out, lad_Y_out, lad_Z_out;
  logic [SW-1:0] lad_s;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ex [NR];
  logic [DW-1:0] ey [NR];
  logic [DW-1:0] ez [NR];
  logic [SW-1:0] es [NR];
  logic manual = 1'b0;
  logic done_man = 1'b1;
  logic done_auto = 1'b1;
  int acnt = 0;
  int starts = 0;
  int wide = 0;
  logic prev_start = 1'b0;

  ladder_arbiter #(.DATA_WIDTH(DW), .SCALAR_WIDTH(SW), .N_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_s(req_s),
    .req_X(req_X), .req_Y(req_Y), .req_Z(req_Z), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_X(rsp_X), .rsp_Y(rsp_Y), .rsp_Z(rsp_Z), .rsp_err(rsp_err),
    .lad_start(lad_start), .lad_s(lad_s), .lad_X(lad_X), .lad_Y(lad_Y), .lad_Z(lad_Z),
    .lad_X_out(lad_X_out), .lad_Y_out(lad_Y_out), .lad_Z_out(lad_Z_out), .lad_done(lad_done));

  always #5 clk = ~clk;

  // Stub ladder: distinguishable function of every operand, done level after 5 cycles
  assign lad_X_out = lad_X + DW'(1);
  assign lad_Y_out = lad_Y ^ lad_s[DW-1:0];
  assign lad_Z_out = ~lad_Z;
  assign lad_done  = manual ? done_man : done_auto;
  always @(posedge clk) begin
    if (lad_start) begin
      done_auto <= 1'b0;
      acnt <= 5;
    end else if (acnt > 0) begin
      acnt <= acnt - 1;
      if (acnt == 1) done_auto <= 1'b1;
    end
  end
  always @(posedge clk) begin
    prev_start <= lad_start;
    if (lad_start) starts <= starts + 1;
    if (lad_start && prev_start) wide <= wide + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic set_req(input int i, input logic [SW-1:0] s, input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
    req_s[i*SW +: SW] = s;
    req_X[i*DW +: DW] = x;
    req_Y[i*DW +: DW] = y;
    req_Z[i*DW +: DW] = z;
    es[i] = s;
    ex[i] = x + DW'(1);
    ey[i] = y ^ s[DW-1:0];
    ez[i] = ~z;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_rsp: rsp_valid=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b need 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b need 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b need 0", rsp_id); end
    checks++; if (rsp_X !== '0 || rsp_Y !== '0 || rsp_Z !== '0) begin errors++; $display("FAIL reset_rsp_xyz: nonzero, need 0"); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b need 0", rsp_err); end
    checks++; if (lad_start !== 1'b0) begin errors++; $display("FAIL reset_lad_start: got %b need 0", lad_start); end
    checks++; if (lad_s !== '0 || lad_X !== '0 || lad_Y !== '0 || lad_Z !== '0) begin errors++; $display("FAIL reset_lad_ops: nonzero, need 0"); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single;
    set_req(0, SW'(10), {7{64'hbad3bf5a_0f1e2d3c}}, {7{64'h94f5d548_a5a5c3c3}}, DW'(64'h0000_0001_0000_0001));
    req_valid = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b need 01", req_ready); end
    @(posedge clk);
    #1 req_valid = 2'b00;
    req_s = '1;
    req_X = '0;
    @(negedge clk);
    checks++; if (lad_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b need 1", lad_start); end
    checks++; if (lad_s !== SW'(10)) begin errors++; $display("FAIL single_lad_s: got %0h need a", lad_s); end
    wait_rsp(50);
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b need 0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b need 0", rsp_err); end
    checks++; if (rsp_X !== ex[0]) begin errors++; $display("FAIL single_X: got %h need %h", rsp_X, ex[0]); end
    checks++; if (rsp_Y !== ey[0]) begin errors++; $display("FAIL single_Y: got %h need %h", rsp_Y, ey[0]); end
    checks++; if (rsp_Z !== ez[0]) begin errors++; $display("FAIL single_Z: got %h need %h", rsp_Z, ez[0]); end
    consume;
  endtask

  task automatic test_round_robin;
    int s0;
    int w0;
    do_reset;
    set_req(0, SW'(123), DW'(100), DW'(200), DW'(300));
    set_req(1, SW'(456), DW'(111), DW'(222), DW'(333));
    s0 = starts;
    w0 = wide;
    req_valid = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first_grant: got %b need 01", req_ready); end
    @(posedge clk);
    #1 req_valid = 2'b10;
    wait_rsp(50);
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rr_id0: got %b need 0", rsp_id); end
    checks++; if (rsp_X !== ex[0]) begin errors++; $display("FAIL rr_X0: got %h need %h", rsp_X, ex[0]); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_ready_in_resp: got %b need 00", req_ready); end
    consume;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_second_grant: got %b need 10", req_ready); end
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp(50);
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL rr_id1: got %b need 1", rsp_id); end
    checks++; if (rsp_Y !== ey[1]) begin errors++; $display("FAIL rr_Y1: got %h need %h", rsp_Y, ey[1]); end
    consume;
    checks++; if (starts - s0 !== 2) begin errors++; $display("FAIL rr_start_count: got %0d need 2", starts - s0); end
    checks++; if (wide - w0 !== 0) begin errors++; $display("FAIL rr_start_width: %0d wide pulses, need 0", wide - w0); end
  endtask

  task automatic test_held_done;
    do_reset;
    manual = 1'b1;
    done_man = 1'b1;
    set_req(0, SW'(77), DW'(5), DW'(6), DW'(7));
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    for (int c = 0; c < HI + LO; c++) begin
      done_man = (c < HI);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL held_no_rsp: cycle %0d got %b need 0", c, rsp_valid); end
      @(posedge clk);
      #1;
    end
    done_man = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL held_done_cycle: got %b need 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL held_rsp_next: got %b need 1", rsp_valid); end
    checks++; if (rsp_Z !== ez[0]) begin errors++; $display("FAIL held_Z: got %h need %h", rsp_Z, ez[0]); end
    consume;
    manual = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset;
    set_req(0, SW'(9), DW'(900), DW'(901), DW'(902));
    set_req(1, SW'(8), DW'(800), DW'(801), DW'(802));
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b10;
    wait_rsp(50);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_X !== ex[0] || rsp_Y !== ey[0] || rsp_Z !== ez[0]) begin
        errors++; $display("FAIL bp_hold: cycle %0d valid=%b id=%b X=%h need 1/0/%h", c, rsp_valid, rsp_id, rsp_X, ex[0]);
      end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready: cycle %0d got %b need 00", c, req_ready); end
    end
    consume;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL b2b_grant: got %b need 10", req_ready); end
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    checks++; if (lad_start !== 1'b1 || lad_s !== es[1]) begin errors++; $display("FAIL b2b_start: start=%b s=%0h need 1/%0h", lad_start, lad_s, es[1]); end
    wait_rsp(50);
    checks++; if (rsp_id !== 1'b1 || rsp_X !== ex[1]) begin errors++; $display("FAIL b2b_rsp: id=%b X=%h need 1/%h", rsp_id, rsp_X, ex[1]); end
    consume;
  endtask

  task automatic test_rst_mid;
    do_reset;
    manual = 1'b1;
    done_man = 1'b1;
    set_req(0, SW'(31), DW'(41), DW'(51), DW'(61));
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    done_man = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || lad_start !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL rst_mid_ctrl: rsp_valid=%b start=%b ready=%b need 0/0/00", rsp_valid, lad_start, req_ready); end
    checks++; if (lad_s !== '0 || lad_X !== '0 || rsp_X !== '0 || rsp_id !== 1'b0) begin errors++; $display("FAIL rst_mid_data: lad_s=%0h lad_X=%0h need 0", lad_s, lad_X); end
    done_man = 1'b1;
    set_req(1, SW'(71), DW'(81), DW'(91), DW'(101));
    @(posedge clk);
    #1 req_valid = 2'b10;
    @(posedge clk);
    #1 req_valid = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale: cycle %0d got %b need 0", c, rsp_valid); end
    end
    @(posedge clk);
    #1 done_man = 1'b0;
    @(posedge clk);
    #1 done_man = 1'b1;
    wait_rsp(10);
    checks++; if (rsp_id !== 1'b1 || rsp_X !== ex[1] || rsp_Z !== ez[1]) begin errors++; $display("FAIL rst_mid_rsp: id=%b X=%h need 1/%h", rsp_id, rsp_X, ex[1]); end
    consume;
    manual = 1'b0;
  endtask

`ifdef LADDER_TIMEOUT_EN
  task automatic test_timeout;
    do_reset;
    manual = 1'b1;
    done_man = 1'b0;
    set_req(0, SW'(3), DW'(13), DW'(23), DW'(33));
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early: cycle %0d got %b need 0", c, rsp_valid); end
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL to_rsp: valid=%b err=%b need 1/1", rsp_valid, rsp_err); end
    checks++; if (rsp_X !== '0 || rsp_Y !== '0 || rsp_Z !== '0) begin errors++; $display("FAIL to_xyz: nonzero, need 0"); end
    consume;
    manual = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_held_done;
    test_back_to_back;
    test_rst_mid;
`ifdef LADDER_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
